// File: rtl/pwm11_meas.sv
// pwm11_meas: recovers the duty value of an 11-bit PWM stream (nominal PERIOD
// clocks per cycle) as a count of high clocks, and flags wrong-period and
// stuck-line conditions.
//   clk, rst       : clock, synchronous active-high reset
//   PWM_sig        : PWM input, asynchronous to clk
//   duty, vld      : last measured high count, one-cycle update strobe
//   per_err        : one-cycle pulse when a measured period differs from PERIOD
//   stuck_lo/hi    : line held low/high for TMO clocks without a rising edge
//   locked         : in MEAS with at least one good period seen
module pwm11_meas #(
  parameter int PERIOD = 2048,
  parameter int TMO    = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PWM_sig,
  output logic [10:0] duty,
  output logic        vld,
  output logic        per_err,
  output logic        stuck_lo,
  output logic        stuck_hi,
  output logic        locked
);

  localparam logic [12:0] PER_C = 13'(PERIOD);
  localparam logic [12:0] TMO_C = 13'(TMO);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MEAS,
    ST_STUCK
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic        r_s1;
  logic        r_s2;
  logic        r_s3;
  logic        w_rise;

  logic [12:0] r_per_cnt;
  logic [11:0] r_hi_cnt;

  logic [10:0] r_duty;
  logic        r_vld;
  logic        r_per_err;
  logic        r_stuck_lo;
  logic        r_stuck_hi;
  logic        r_locked;

  logic [10:0] w_duty_nxt;
  logic        w_vld_nxt;
  logic        w_per_err_nxt;
  logic        w_stuck_lo_nxt;
  logic        w_stuck_hi_nxt;
  logic        w_locked_nxt;
  logic        w_to_stuck;

  assign w_rise = r_s2 & ~r_s3;

  // Synchroniser plus history flop for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= PWM_sig;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  // Counters run in every state; a rise reloads them with 1 so the values
  // seen during the rise cycle describe the whole previous period.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_per_cnt <= '0;
      r_hi_cnt  <= '0;
    end else if (w_rise) begin
      r_per_cnt <= 13'd1;
      r_hi_cnt  <= 12'd1;
    end else begin
      if (r_per_cnt != '1)
        r_per_cnt <= r_per_cnt + 13'd1;
      if (r_s2 && (r_hi_cnt != '1))
        r_hi_cnt <= r_hi_cnt + 12'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      r_state <= ST_IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_duty_nxt     = r_duty;
    w_vld_nxt      = 1'b0;
    w_per_err_nxt  = 1'b0;
    w_stuck_lo_nxt = r_stuck_lo;
    w_stuck_hi_nxt = r_stuck_hi;
    w_locked_nxt   = r_locked;
    w_to_stuck     = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_rise)
          w_state_nxt = ST_MEAS;
        else if (r_per_cnt == TMO_C)
          w_to_stuck = 1'b1;
      end
      ST_MEAS: begin
        if (w_rise) begin
          if (r_per_cnt == PER_C) begin
            w_duty_nxt   = r_hi_cnt[10:0];
            w_vld_nxt    = 1'b1;
            w_locked_nxt = 1'b1;
          end else begin
            w_per_err_nxt = 1'b1;
            w_locked_nxt  = 1'b0;
          end
        end else if (r_per_cnt == TMO_C) begin
          w_to_stuck = 1'b1;
        end
      end
      ST_STUCK: begin
        if (w_rise) begin
          w_state_nxt    = ST_MEAS;
          w_stuck_lo_nxt = 1'b0;
          w_stuck_hi_nxt = 1'b0;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    // Stuck entry is shared by IDLE and MEAS; the counter keeps running past
    // TMO while in STUCK, so the entry reports exactly once.
    if (w_to_stuck) begin
      w_state_nxt  = ST_STUCK;
      w_vld_nxt    = 1'b1;
      w_locked_nxt = 1'b0;
      if (r_s2) begin
        w_stuck_hi_nxt = 1'b1;
        w_duty_nxt     = '1;
      end else begin
        w_stuck_lo_nxt = 1'b1;
        w_duty_nxt     = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_duty     <= '0;
      r_vld      <= 1'b0;
      r_per_err  <= 1'b0;
      r_stuck_lo <= 1'b0;
      r_stuck_hi <= 1'b0;
      r_locked   <= 1'b0;
    end else begin
      r_duty     <= w_duty_nxt;
      r_vld      <= w_vld_nxt;
      r_per_err  <= w_per_err_nxt;
      r_stuck_lo <= w_stuck_lo_nxt;
      r_stuck_hi <= w_stuck_hi_nxt;
      r_locked   <= w_locked_nxt;
    end
  end

  assign duty     = r_duty;
  assign vld      = r_vld;
  assign per_err  = r_per_err;
  assign stuck_lo = r_stuck_lo;
  assign stuck_hi = r_stuck_hi;
  assign locked   = r_locked;

endmodule

// File: tb/tb_pwm11_meas.sv
module tb_pwm11_meas;

  localparam int PERIOD = 2048;
  localparam int TMO    = 4096;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        PWM_sig = 1'b0;
  logic [10:0] duty;
  logic        vld;
  logic        per_err;
  logic        stuck_lo;
  logic        stuck_hi;
  logic        locked;

  pwm11_meas #(.PERIOD(PERIOD), .TMO(TMO)) dut (
    .clk      (clk),
    .rst      (rst),
    .PWM_sig  (PWM_sig),
    .duty     (duty),
    .vld      (vld),
    .per_err  (per_err),
    .stuck_lo (stuck_lo),
    .stuck_hi (stuck_hi),
    .locked   (locked)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // kind: 1 = vld, 2 = per_err
  typedef struct {
    int kind;
    int duty;
    int cyc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   last_rise = 0;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic push(input int kind, input int d, input int c);
    exp_t e;
    e.kind = kind;
    e.duty = d;
    e.cyc  = c;
    q.push_back(e);
  endtask

  // One PWM period: high for hi clocks then low. The rising edge at its start
  // reports the previous period (kind/dval); stk >= 0 also expects a stuck
  // report TMO clocks after that edge.
  task automatic run_period(input int hi, input int per, input int kind,
                            input int dval, input int stk);
    for (int i = 0; i < per; i++) begin
      @(negedge clk);
      if (i == 0 && hi > 0 && PWM_sig == 1'b0) begin
        last_rise = cyc;
        if (kind != 0) push(kind, dval, cyc + 3);
        if (stk >= 0) push(1, stk, cyc + 3 + TMO);
      end
      PWM_sig = (i < hi);
    end
  endtask

  // Monitor: every vld/per_err pulse must match the head of the queue.
  always @(negedge clk) begin
    if (vld || per_err) begin
      exp_t e;
      checks++;
      if (vld && per_err) begin
        errors++;
        $display("FAIL vld_and_per_err: both high at cycle %0d, required exclusive", cyc);
      end
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: vld=%0b per_err=%0b duty=%0d at cycle %0d, none expected",
                 vld, per_err, duty, cyc);
      end else begin
        e = q.pop_front();
        chk("pulse_kind", vld ? 1 : 2, e.kind);
        chk("pulse_duty", int'(duty), e.duty);
        chk("pulse_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic chk_all(input string tag, input int d, input int lo, input int hi, input int lk);
    chk({tag, "_duty"}, int'(duty), d);
    chk({tag, "_stuck_lo"}, int'(stuck_lo), lo);
    chk({tag, "_stuck_hi"}, int'(stuck_hi), hi);
    chk({tag, "_locked"}, int'(locked), lk);
  endtask

  initial begin
    // Reset state
    repeat (4) @(negedge clk);
    chk_all("reset", 0, 0, 0, 0);
    chk("reset_vld", int'(vld), 0);
    chk("reset_per_err", int'(per_err), 0);
    @(negedge clk);
    rst = 1'b0;

    // 1: nominal duty 512
    run_period(512, 2048, 0, 0, -1);
    chk("t1_locked_first_edge", int'(locked), 0);
    run_period(512, 2048, 1, 512, -1);
    chk("t1_locked_second_edge", int'(locked), 1);
    run_period(512, 2048, 1, 512, -1);

    // 2: extreme duties, transition reports the old value
    run_period(1, 2048, 1, 512, -1);
    run_period(1, 2048, 1, 1, -1);
    run_period(2047, 2048, 1, 1, -1);
    run_period(2047, 2048, 1, 2047, -1);
    run_period(2047, 2048, 1, 2047, -1);
    chk("t2_duty", int'(duty), 2047);

    // 3: stuck low then recovery with duty 1024
    push(1, 0, last_rise + 3 + TMO);
    run_period(0, 4300, 0, 0, -1);
    chk_all("t3_stuck", 0, 1, 0, 0);
    run_period(1024, 2048, 0, 0, -1);
    chk("t3_stuck_lo_cleared", int'(stuck_lo), 0);
    run_period(1024, 2048, 1, 1024, -1);
    chk("t3_duty", int'(duty), 1024);

    // 4: stuck high for 5000 clocks
    run_period(5000, 5000, 1, 1024, 2047);
    chk_all("t4_stuck", 2047, 0, 1, 0);

    // 5: lock on duty 1000, then 2000-clock periods
    run_period(0, 500, 0, 0, -1);
    run_period(1000, 2048, 0, 0, -1);
    chk("t5_stuck_hi_cleared", int'(stuck_hi), 0);
    run_period(1000, 2048, 1, 1000, -1);
    chk("t5_locked_good", int'(locked), 1);
    run_period(1000, 2000, 1, 1000, -1);
    run_period(1000, 2000, 2, 1000, -1);
    run_period(1000, 2000, 2, 1000, -1);
    chk_all("t5_wrong_period", 1000, 0, 0, 0);

    // 6: reset for 2048 clocks in the middle of a duty-1024 period
    run_period(1024, 1024, 2, 1000, -1);
    for (int i = 0; i < 2048; i++) begin
      @(negedge clk);
      rst = 1'b1;
      PWM_sig = (i >= 1024);
    end
    chk_all("t6_in_reset", 0, 0, 0, 0);
    chk("t6_in_reset_vld", int'(vld), 0);
    chk("t6_in_reset_per_err", int'(per_err), 0);
    @(negedge clk);
    rst = 1'b0;
    PWM_sig = 1'b0;
    run_period(0, 1023, 0, 0, -1);
    run_period(1536, 2048, 0, 0, -1);
    chk("t6_no_vld_first_edge", int'(duty), 0);
    run_period(1536, 2048, 1, 1536, -1);
    chk_all("t6_final", 1536, 0, 0, 1);

    repeat (8) @(negedge clk);
    chk("pending_expectations", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pwm11_meas.md
# pwm11_meas

Measures an 11-bit PWM waveform (nominal 2048-clock period, as produced by `PWM11`) and recovers the duty value as an 11-bit count of high clocks per period. It sits on the receiving end of a PWM link, for example closing a loop on a motor-drive output or checking `PWM11` in-system. It also flags wrong-period and stuck-line conditions.

## Interface

**Parameters**
- `PERIOD`, default 2048: nominal PWM period in clocks.
- `TMO`, default 4096: clocks without a rising edge before the line is declared stuck. Must exceed `PERIOD`.

**Ports** (name, direction, width, meaning)
- `clk`, in, 1: sole clock; all state updates on its rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `PWM_sig`, in, 1: PWM input; asynchronous to `clk`.
- `duty`, out, 11: last measured high-clock count.
- `vld`, out, 1: one-cycle pulse when `duty` has just been updated.
- `per_err`, out, 1: one-cycle pulse when a period measured ≠ `PERIOD`.
- `stuck_lo`, out, 1: level; line has been low for `TMO` clocks.
- `stuck_hi`, out, 1: level; line has been high for `TMO` clocks.
- `locked`, out, 1: level; high while in MEAS after at least one good period.

## Operation

**Input conditioning**
- `PWM_sig` passes through 2 flops (`s1`, `s2`) plus a history flop `s3`.
- `rise` = `s2 & ~s3`. All measurement uses `s2`.

**Counters**
- `per_cnt`: 13 bits, saturates at 8191.
- `hi_cnt`: 12 bits, saturates at 4095.
- On a `rise` cycle: `per_cnt`←1, `hi_cnt`←1.
- Otherwise: `per_cnt`+=1, `hi_cnt`+=`s2`.
- At a `rise`, the pre-load values therefore equal the clocks in the previous period and the high clocks within it.

**FSM** (states IDLE, MEAS, STUCK)
- **IDLE** (reset state): counters run.
  - `rise` → MEAS. Load counters; no `vld` (first edge has no prior period).
  - `per_cnt == TMO` → STUCK.
- **MEAS**:
  - `rise` with `per_cnt == PERIOD`: `duty`←`hi_cnt[10:0]`, `vld` pulse, `locked`←1.
  - `rise` with `per_cnt != PERIOD`: `per_err` pulse, `locked`←0, `duty` held, no `vld`.
  - `per_cnt == TMO` → STUCK.
- **STUCK**:
  - On entry:
    - If `s2==0`: `stuck_lo`←1, `duty`←0, one `vld` pulse.
    - If `s2==1`: `stuck_hi`←1, `duty`←2047, one `vld` pulse.
    - `locked`←0.
  - Remains in STUCK with no further pulses.
  - `rise` → MEAS: clear both stuck flags and load counters; no `vld`.

**Boundaries**
- `rst` overrides all other inputs that cycle.
- Reset mid-period discards the partial measurement and returns to IDLE.
- `hi_cnt == PERIOD` cannot pair with a valid period, because a rising edge requires at least 1 low clock. Duty 2047 is the maximum valid report.
- `vld` and `per_err` are never asserted in the same cycle.

## Timing

**Reset values**
- `duty`=0; `vld`, `per_err`, `stuck_lo`, `stuck_hi`, `locked` = 0.
- `s1`..`s3` = 0; counters = 0; state = IDLE.

**Latency**
- Input rise to `rise` cycle: 2 clocks; `rise` is asserted in the cycle after `s2` captures 1.
- `vld` and `per_err` are registered and assert in the cycle after `rise`, i.e. 3 clocks after the input edge.
- `duty` is valid in the same cycle as `vld` and holds until the next update.

**Stuck detection**
- STUCK entry occurs `TMO` clocks after the last `rise`, or `TMO` clocks after reset if no edge has been seen.
- `stuck_*` and the associated `vld` assert in the cycle after entry.

**Throughput**
- One `vld` per input period.
- The first `vld` occurs on the second rising edge after leaving IDLE or STUCK.

## Test plan

1. **Nominal duty 512.** Drive the DUT from a `PWM11` model with duty 512 for 3 periods. Require: `vld` every 2048 clocks with `duty`=512, and `locked`=1 after the second edge.
2. **Extreme duties.** Duty 1, then duty 2047. Require: reported `duty` of 1 and 2047 respectively; `per_err` is never asserted; the transition period reports either the old or new value, never `per_err`.
3. **Stuck low then recovery.** Duty 0 (line held low). Require: 4096 clocks after the last edge, `stuck_lo`=1 with one `vld` and `duty`=0. Then apply duty 1024; require `stuck_lo` clears on the first edge and `duty`=1024 on the next edge.
4. **Stuck high.** Hold `PWM_sig`=1 for 5000 clocks. Require: `stuck_hi`=1, `duty`=2047, exactly one `vld`.
5. **Wrong period.** Drive a 2000-clock period with 1000 clocks high. Require: `per_err` pulse per edge, no `vld`, `locked`=0, `duty` unchanged.
6. **Reset mid-period.** Assert `rst` for 2048 clocks in the middle of a duty-1024 period, then apply duty 1536. Require: all outputs 0 during reset; the first `vld` comes on the second rising edge after release, with `duty`=1536.
